utopia1_phy_tx: RTL and testbench

- Utopia Level-1 PHY-side cell source. It is the far end of the ATM receive port (TopReceive direction) and drives data, soc and clav into the switch receiver.
- The testbench or upstream model loads cells as a byte stream. The block buffers up to two complete 53-byte cells.
- Cells are emitted octet by octet under control of the receiver's active-low enable.
- Used as the synthesizable stimulus/loopback source in the ATM switch environment.

---
 rtl/atm_pkg.sv | 34 +++
 rtl/atm_cell_ram.sv | 26 ++
 rtl/utopia1_phy_tx.sv | 156 +++++++++++++++
 tb/tb_utopia1_phy_tx.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the Utopia Level-1 cell path.
// Used by the PHY-side cell source and its cell buffer.
package atm_pkg;

    localparam int CELL_BYTES = 53;
    localparam int NUM_SLOTS  = 2;
    localparam int RAM_DEPTH  = NUM_SLOTS * CELL_BYTES;

    localparam logic [5:0] LAST_IDX = 6'(CELL_BYTES - 1);

    typedef logic [7:0] octet_t;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_FILL,
        SLOT_FULL,
        SLOT_SEND
    } slot_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_READY,
        TX_SEND
    } tx_state_t;

    // Flat address of octet idx inside cell buffer slot.
    function automatic logic [6:0] ram_addr(
        input logic       slot,
        input logic [5:0] idx
    );
        return (slot ? 7'(CELL_BYTES) : 7'd0) + {1'b0, idx};
    endfunction

endpackage

// File: rtl/atm_cell_ram.sv
// Two-cell octet buffer: one write port, one asynchronous read port.
// Storage has no reset; slot state tracks validity.
module atm_cell_ram
    import atm_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_wr_en,
    input  logic       i_wr_slot,
    input  logic [5:0] i_wr_idx,
    input  octet_t     i_wr_data,
    input  logic       i_rd_slot,
    input  logic [5:0] i_rd_idx,
    output octet_t     o_rd_data
);

    octet_t r_mem [RAM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[ram_addr(i_wr_slot, i_wr_idx)] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[ram_addr(i_rd_slot, i_rd_idx)];

endmodule

// File: rtl/utopia1_phy_tx.sv
// Utopia Level-1 PHY-side cell source: buffers two cells from a byte
// loader and plays them out under the receiver's active-low enable.
module utopia1_phy_tx
    import atm_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_sop,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       in_err,
    input  logic       en,
    output logic [7:0] data,
    output logic       soc,
    output logic       clav
);

    slot_state_t [NUM_SLOTS-1:0] r_slot;
    slot_state_t [NUM_SLOTS-1:0] w_slot_nxt;

    tx_state_t  r_state;
    logic       r_wr_slot;
    logic       r_rd_slot;
    logic [5:0] r_wr_idx;
    logic [5:0] r_rd_idx;
    octet_t     r_data;
    logic       r_soc;
    logic       r_clav;
    logic       r_err;

    logic       w_accept;
    logic       w_wr_en;
    logic [5:0] w_wr_idx;
    logic       w_wr_last;
    logic       w_wr_err;
    logic       w_start;
    logic       w_adv;
    logic       w_rd_last;
    logic       w_nxt_rd_slot;
    logic       w_full_any;
    octet_t     w_rd_data;

    // Write side only ever targets the slot at the write pointer.
    assign in_ready  = (r_slot[r_wr_slot] == SLOT_FREE) ||
                       (r_slot[r_wr_slot] == SLOT_FILL);
    assign w_accept  = in_valid & in_ready;
    assign w_wr_en   = w_accept & (in_sop | (r_wr_idx != 6'd0));
    assign w_wr_idx  = in_sop ? 6'd0 : r_wr_idx;
    assign w_wr_last = w_accept & ~in_sop & (r_wr_idx == LAST_IDX);
    assign w_wr_err  = w_accept & (in_sop ? (r_wr_idx != 6'd0)
                                          : (r_wr_idx == 6'd0));

    assign w_start       = (r_state == TX_READY) & ~en;
    assign w_adv         = (r_state == TX_SEND) & ~en;
    assign w_rd_last     = w_adv & (r_rd_idx == LAST_IDX);
    assign w_nxt_rd_slot = ~r_rd_slot;

    // Write and read never touch the same slot on one edge.
    always_comb begin
        w_slot_nxt = r_slot;
        if (w_accept & in_sop) w_slot_nxt[r_wr_slot] = SLOT_FILL;
        if (w_wr_last)         w_slot_nxt[r_wr_slot] = SLOT_FULL;
        if (w_start)           w_slot_nxt[r_rd_slot] = SLOT_SEND;
        if (w_rd_last)         w_slot_nxt[r_rd_slot] = SLOT_FREE;
    end

    always_comb begin
        w_full_any = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_slot_nxt[i] == SLOT_FULL) w_full_any = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= SLOT_FREE;
            r_wr_slot <= 1'b0;
            r_wr_idx  <= 6'd0;
            r_err     <= 1'b0;
            r_clav    <= 1'b0;
        end else begin
            r_slot <= w_slot_nxt;
            r_err  <= w_wr_err;
            r_clav <= w_full_any;
            if (w_accept) begin
                if (in_sop) begin
                    r_wr_idx <= 6'd1;
                end else if (w_wr_last) begin
                    r_wr_idx  <= 6'd0;
                    r_wr_slot <= ~r_wr_slot;
                end else if (r_wr_idx != 6'd0) begin
                    r_wr_idx <= r_wr_idx + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_rd_slot <= 1'b0;
            r_rd_idx  <= 6'd0;
            r_data    <= 8'd0;
            r_soc     <= 1'b0;
        end else begin
            unique case (r_state)
                TX_IDLE: begin
                    if (!en) r_soc <= 1'b0;
                    if (r_slot[r_rd_slot] == SLOT_FULL) r_state <= TX_READY;
                end
                TX_READY: begin
                    if (!en) begin
                        r_data   <= w_rd_data;
                        r_soc    <= 1'b1;
                        r_rd_idx <= 6'd1;
                        r_state  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!en) begin
                        r_data <= w_rd_data;
                        r_soc  <= 1'b0;
                        if (r_rd_idx == LAST_IDX) begin
                            r_rd_idx  <= 6'd0;
                            r_rd_slot <= w_nxt_rd_slot;
                            r_state   <=
                                (w_slot_nxt[w_nxt_rd_slot] == SLOT_FULL)
                                ? TX_READY : TX_IDLE;
                        end else begin
                            r_rd_idx <= r_rd_idx + 6'd1;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    atm_cell_ram u_ram (
        .i_clk     (clk_in),
        .i_wr_en   (w_wr_en),
        .i_wr_slot (r_wr_slot),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (in_data),
        .i_rd_slot (r_rd_slot),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    assign data   = r_data;
    assign soc    = r_soc;
    assign clav   = r_clav;
    assign in_err = r_err;

endmodule

// File: tb/tb_utopia1_phy_tx.sv
// Self-checking bench for utopia1_phy_tx against a cell-queue model.
module tb_utopia1_phy_tx;

    localparam int CB = 53;
    typedef logic [7:0] cell_t [CB];

    logic       clk_in = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_valid;
    logic       in_ready;
    logic       in_err;
    logic       en;
    logic [7:0] data;
    logic       soc;
    logic       clav;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_cur [$];
    cell_t      m_q   [$];

    utopia1_phy_tx dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .in_data  (in_data),
        .in_sop   (in_sop),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_err   (in_err),
        .en       (en),
        .data     (data),
        .soc      (soc),
        .clav     (clav)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Loader model: returns the expected in_err for an accepted octet.
    function automatic logic model_write(input logic [7:0] d, input logic s);
        logic  err;
        cell_t c;
        err = 1'b0;
        if (s) begin
            err = (m_cur.size() != 0);
            m_cur.delete();
            m_cur.push_back(d);
        end else if (m_cur.size() == 0) begin
            err = 1'b1;
        end else begin
            m_cur.push_back(d);
            if (m_cur.size() == CB) begin
                for (int i = 0; i < CB; i++) c[i] = m_cur[i];
                m_q.push_back(c);
                m_cur.delete();
            end
        end
        return err;
    endfunction

    function automatic cell_t rand_cell();
        cell_t c;
        for (int i = 0; i < CB; i++) c[i] = 8'($urandom);
        return c;
    endfunction

    task automatic push_octet(input logic [7:0] d, input logic s, input string tag);
        logic exp_err;
        logic exp_rdy;
        exp_rdy = (m_q.size() < 2);
        n_checks++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s in_ready: got %b want %b", tag, in_ready, exp_rdy);
        end
        if (!exp_rdy) return;
        in_data  = d;
        in_sop   = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        exp_err  = model_write(d, s);
        n_checks++;
        if (in_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s in_err: got %b want %b", tag, in_err, exp_err);
        end
        n_checks++;
        if (clav !== (m_q.size() != 0)) begin
            n_fail++;
            $display("FAIL %s clav_load: got %b want %b", tag, clav, m_q.size() != 0);
        end
    endtask

    task automatic load_cell(input cell_t c, input string tag);
        en = 1'b1;
        push_octet(c[0], 1'b1, tag);
        for (int i = 1; i < CB; i++) push_octet(c[i], 1'b0, tag);
    endtask

    // Plays out every queued cell; returns edges from en low to first soc.
    task automatic drain(input int stop_at, input int pause_at, input int pause_len,
                         input bit rnd, input string tag, output int lat);
        logic [7:0] flat [$];
        int  n;
        int  pos;
        int  paused;
        bit  got;
        bit  e;
        n = m_q.size();
        foreach (m_q[k]) for (int i = 0; i < CB; i++) flat.push_back(m_q[k][i]);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            en = 1'b0;
            tick();
            lat++;
            if (soc === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s soc_timeout: got soc=%b want 1 within 8 edges", tag, soc);
            m_q.delete();
            en = 1'b1;
            return;
        end
        pos    = 0;
        paused = 0;
        forever begin
            n_checks++;
            if (data !== flat[pos] || soc !== (pos % CB == 0)) begin
                n_fail++;
                $display("FAIL %s octet[%0d]: got %h/soc%b want %h/soc%b",
                         tag, pos, data, soc, flat[pos], pos % CB == 0);
            end
            n_checks++;
            if (clav !== ((n - pos / CB - 1) > 0)) begin
                n_fail++;
                $display("FAIL %s clav[%0d]: got %b want %b",
                         tag, pos, clav, (n - pos / CB - 1) > 0);
            end
            n_checks++;
            if (in_ready !== ((n - (pos + 1) / CB) < 2)) begin
                n_fail++;
                $display("FAIL %s in_ready[%0d]: got %b want %b",
                         tag, pos, in_ready, (n - (pos + 1) / CB) < 2);
            end
            if (pos == flat.size() - 1 || pos == stop_at) break;
            if (rnd) e = ($urandom_range(0, 2) == 0);
            else     e = (pos == pause_at && paused < pause_len);
            if (e && pos == pause_at) paused++;
            en = e;
            tick();
            if (!e) pos++;
        end
        en = 1'b1;
        if (pos == flat.size() - 1) m_q.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        en       = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        n_checks++;
        if ({data, soc, clav, in_err, in_ready} !== {8'h00, 4'b0001}) begin
            n_fail++;
            $display("FAIL reset_state: got d=%h soc=%b clav=%b err=%b rdy=%b want 00 0 0 0 1",
                     data, soc, clav, in_err, in_ready);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({soc, clav, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_release: got soc=%b clav=%b rdy=%b want 0 0 1",
                     soc, clav, in_ready);
        end
    endtask

    task automatic test_single_cell();
        cell_t c;
        int    lat;
        for (int i = 0; i < CB; i++) c[i] = 8'(i);
        load_cell(c, "single");
        tick();
        drain(-1, -1, 0, 1'b0, "single", lat);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d edges want 1", lat);
        end
    endtask

    task automatic test_back_to_back();
        cell_t a;
        cell_t b;
        int    lat;
        for (int i = 0; i < CB; i++) begin
            a[i] = 8'hA0 + 8'(i);
            b[i] = 8'hB0 + 8'(i);
        end
        load_cell(a, "b2b_A");
        load_cell(b, "b2b_B");
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full_ready: got %b want 0", in_ready);
        end
        in_data  = 8'hC0;
        in_sop   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        n_checks++;
        if (in_err !== 1'b0 || clav !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_third: got err=%b clav=%b want 0 1", in_err, clav);
        end
        drain(-1, -1, 0, 1'b0, "b2b", lat);
    endtask

    task automatic test_pause();
        int lat;
        load_cell(rand_cell(), "pause");
        drain(-1, 10, 5, 1'b0, "pause", lat);
    endtask

    task automatic test_sop_restart();
        int lat;
        en = 1'b1;
        push_octet(8'($urandom), 1'b1, "restart_pre");
        for (int i = 1; i < 20; i++) push_octet(8'($urandom), 1'b0, "restart_pre");
        load_cell(rand_cell(), "restart");
        drain(-1, -1, 0, 1'b0, "restart", lat);
    endtask

    task automatic test_orphan();
        int lat;
        en = 1'b1;
        push_octet(8'h5A, 1'b0, "orphan");
        n_checks++;
        if (in_ready !== 1'b1 || clav !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_state: got rdy=%b clav=%b want 1 0", in_ready, clav);
        end
        load_cell(rand_cell(), "orphan_next");
        drain(-1, -1, 0, 1'b0, "orphan_next", lat);
    endtask

    task automatic test_async_reset();
        int lat;
        bit bad;
        load_cell(rand_cell(), "arst");
        drain(30, -1, 0, 1'b0, "arst", lat);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({data, soc, clav, in_ready} !== {8'h00, 3'b001}) begin
            n_fail++;
            $display("FAIL arst_immediate: got d=%h soc=%b clav=%b rdy=%b want 00 0 0 1",
                     data, soc, clav, in_ready);
        end
        tick();
        reset = 1'b0;
        m_q.delete();
        m_cur.delete();
        en  = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (soc !== 1'b0 || clav !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL arst_quiet: got soc/clav activity want none");
        end
        load_cell(rand_cell(), "arst_new");
        drain(-1, -1, 0, 1'b0, "arst_new", lat);
    endtask

    task automatic test_random();
        int lat;
        int k;
        for (int it = 0; it < 6; it++) begin
            en = 1'b1;
            if ($urandom_range(0, 1) == 1) push_octet(8'($urandom), 1'b0, "rnd_orphan");
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, 50);
                push_octet(8'($urandom), 1'b1, "rnd_partial");
                for (int i = 0; i < k; i++) push_octet(8'($urandom), 1'b0, "rnd_partial");
            end
            load_cell(rand_cell(), "rnd");
            if ($urandom_range(0, 1) == 1) load_cell(rand_cell(), "rnd");
            drain(-1, -1, 0, 1'b1, "rnd", lat);
        end
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_back_to_back();
        test_pause();
        test_sop_restart();
        test_orphan();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
